// File: rtl/fetch_seq.sv
// fetch_seq: instruction fetch and data-access sequencer.
// Fetches instruction bytes at pc and hands each one to the controller for a
// single EXEC cycle. On request it performs one load or store on the shared
// memory bus, then resumes fetching. It owns the program counter.
// Optional build macro: FETCH_TIMEOUT_EN adds an ack-wait watchdog. When the
// watchdog fires it halts the sequencer and sets a sticky bus_err.
module fetch_seq #(
  parameter int                ADDR_W         = 16,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter int                TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  output logic [7:0]        instr,
  output logic              instr_valid,
  input  logic              fetch,
  input  logic              we,
  input  logic [3:0]        addr_offset,
  input  logic [ADDR_W-1:0] data_base,
  input  logic [7:0]        store_data,
  output logic [7:0]        load_data,
  output logic              load_valid,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    S_IFETCH = 2'd0,
    S_EXEC   = 2'd1,
    S_DATA   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [7:0]        instr_q;
  logic [7:0]        load_data_q;
  logic              load_valid_q;
  logic [ADDR_W-1:0] dat_addr_q;
  logic              dat_we_q;
  logic [7:0]        dat_wdata_q;
  logic              in_req;
  logic              take_data;
  logic              timeout_hit;

  assign in_req    = (state_q == S_IFETCH) || (state_q == S_DATA);
  assign take_data = (state_q == S_EXEC) && !halt && fetch;

  // Next state and bus/strobe decode. Bus outputs are forced low while reset is
  // asserted, so a reset during a transfer abandons it in the same cycle.
  always_comb begin
    state_d     = state_q;
    instr_valid = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state_q)
      S_IFETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack)          state_d = S_EXEC;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        if (halt)       state_d = S_HALT;
        else if (fetch) state_d = S_DATA;
        else            state_d = S_IFETCH;
      end
      S_DATA: begin
        mem_req   = 1'b1;
        mem_we    = dat_we_q;
        mem_addr  = dat_addr_q;
        mem_wdata = dat_wdata_q;
        if (mem_ack)          state_d = S_IFETCH;
        else if (timeout_hit) state_d = S_HALT;
      end
      default: begin
        // HALT: bus idle, only reset leaves this state
      end
    endcase
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  // State, program counter, fetched instruction and load result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IFETCH;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_valid_q <= (state_q == S_DATA) && mem_ack && !dat_we_q;
      if ((state_q == S_IFETCH) && mem_ack) begin
        instr_q <= mem_rdata;
        pc_q    <= pc_q + ADDR_W'(1);
      end
      if ((state_q == S_DATA) && mem_ack && !dat_we_q) begin
        load_data_q <= mem_rdata;
      end
    end
  end

  // Capture the data access during EXEC so that address, direction and write
  // data stay stable for the whole DATA request.
  always_ff @(posedge clk) begin
    if (take_data) begin
      dat_addr_q  <= data_base + ADDR_W'(addr_offset);
      dat_we_q    <= we;
      dat_wdata_q <= store_data;
    end
  end

  assign instr      = instr_q;
  assign pc         = pc_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             bus_err_q;

  // The watchdog fires on the last unanswered cycle. mem_ack in that same
  // cycle still completes the transfer normally.
  assign timeout_hit = in_req && !mem_ack && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Count unanswered request cycles; any cycle that is not waiting restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (in_req && !mem_ack) tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      else                    tmo_cnt_q <= '0;
      if (timeout_hit) bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^{in_req, TIMEOUT_CYCLES};
  assign timeout_hit    = 1'b0;
  assign bus_err        = 1'b0;
`endif

endmodule
